// File: rtl/alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_scheduler
// Description : Round-robin scheduler sharing one combinational ALU + flag
//               calculator between two requesters. Holds operands for LAT
//               cycles, captures result/flags and returns them tagged with
//               the requester id on a valid/ready response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_scheduler #(
  parameter int W   = 4,
  parameter int OPW = 4,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [OPW-1:0] req0_opcode,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic [OPW-1:0] req1_opcode,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic [OPW-1:0] alu_opcode,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic           alu_start,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_negative,
  input  logic           alu_overflow,
  input  logic           alu_zero,
  input  logic           alu_cout,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_result,
  output logic [3:0]     rsp_flags,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Countdown start value: capture happens when the counter reaches zero.
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

  state_t         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [OPW-1:0] alu_opcode_q, alu_opcode_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic           alu_start_q, alu_start_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;
  logic [1:0]     grant;

  // Round-robin grant: on a tie the requester that was not served last wins.
  always_comb begin
    grant    = 2'b00;
    grant[0] = req_valid[0] & (~req_valid[1] | last_grant_q);
    grant[1] = req_valid[1] & (~req_valid[0] | ~last_grant_q);
  end

  // Next-state, datapath capture and handshake logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_start_d  = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    req_ready    = 2'b00;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (grant[1]) begin
          alu_opcode_d = req1_opcode;
          alu_a_d      = req1_a;
          alu_b_d      = req1_b;
          rsp_id_d     = 1'b1;
          cnt_d        = CNT_INIT;
          alu_start_d  = 1'b1;
          state_d      = EXEC;
        end else if (grant[0]) begin
          alu_opcode_d = req0_opcode;
          alu_a_d      = req0_a;
          alu_b_d      = req0_b;
          rsp_id_d     = 1'b0;
          cnt_d        = CNT_INIT;
          alu_start_d  = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_negative, alu_overflow, alu_zero, alu_cout};
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = rsp_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= 3'd0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_start_q  <= alu_start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_scheduler
// Description : Scoreboard bench for alu_req_scheduler with a latency-aware
//               behavioural ALU and a cycle-level arbitration/timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_scheduler;

  localparam int W   = 4;
  localparam int OPW = 4;
  localparam int LAT = 3;

  localparam logic [3:0] ADD_OP = 4'd0;
  localparam logic [3:0] SUB_OP = 4'd1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid, req_ready;
  logic [OPW-1:0] req0_opcode, req1_opcode, alu_opcode;
  logic [W-1:0]   req0_a, req0_b, req1_a, req1_b, alu_a, alu_b;
  logic           alu_start;
  logic [W-1:0]   alu_result;
  logic           alu_negative, alu_overflow, alu_zero, alu_cout;
  logic           rsp_valid, rsp_ready, rsp_id, busy;
  logic [W-1:0]   rsp_result;
  logic [3:0]     rsp_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_scheduler #(.W(W), .OPW(OPW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {N,V,Z,C,result}.
  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    int unsigned s;
    logic [3:0]  r;
    logic        c, v;
    c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        s = a + b; r = 4'(s); c = (s > 15);
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      default: r = ~a;
    endcase
    return {r[3], v, (r == 4'd0), c, r};
  endfunction

  // Bench ALU: answer is only correct once operands have been stable LAT cycles.
  int exec_age;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !busy) exec_age <= 0;
    else if (alu_start)  exec_age <= 2;
    else if (exec_age < 100) exec_age <= exec_age + 1;
  end

  logic [7:0] alu_out;
  always_comb begin
    alu_out = alu_ref(alu_opcode, alu_a, alu_b);
    if ((alu_start ? 1 : exec_age) < LAT) alu_out = alu_out ^ 8'hA5;
    {alu_negative, alu_overflow, alu_zero, alu_cout, alu_result} = alu_out;
  end

  // Scoreboard entries: {id, flags, result}.
  logic [8:0] exp_q[$];

  // Cycle-level model of arbitration and timing.
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       m_out;
  logic       m_last;
  logic       m_id;
  int         m_acc_cyc;
  logic [11:0] m_ops;
  int         acc_count = 0;
  logic [1:0] acc_ids[$];

  always @(negedge clk) begin
    logic [1:0] e_rdy;
    logic       e_rv;
    if (!rst_n) begin
      m_out = 1'b0; m_last = 1'b1; m_acc_cyc = 0;
    end else begin
      e_rdy = 2'b00;
      if (!m_out) begin
        if (req_valid == 2'b11) e_rdy = m_last ? 2'b01 : 2'b10;
        else                    e_rdy = req_valid;
      end
      e_rv = m_out && (cyc >= m_acc_cyc + LAT + 1);
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("busy", 32'(busy), 32'(m_out));
      chk("alu_start", 32'(alu_start), 32'(m_out && (cyc == m_acc_cyc + 1)));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      if (m_out) chk("alu_operands", 32'({alu_opcode, alu_a, alu_b}), 32'(m_ops));
      if (e_rv && rsp_valid && rsp_ready) begin
        m_out  = 1'b0;
        m_last = m_id;
      end else if (e_rdy != 2'b00) begin
        m_out     = 1'b1;
        m_id      = e_rdy[1];
        m_acc_cyc = cyc;
        m_ops     = m_id ? {req1_opcode, req1_a, req1_b} : {req0_opcode, req0_a, req0_b};
        exp_q.push_back({m_id, alu_ref(m_ops[11:8], m_ops[7:4], m_ops[3:0])});
        acc_ids.push_back({1'b0, m_id});
        acc_count++;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks hold stability.
  logic       p_stall;
  logic [8:0] p_rsp;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      exp_q.delete();
      p_stall = 1'b0;
    end else begin
      if (p_stall && rsp_valid) chk("rsp_hold", 32'({rsp_id, rsp_flags, rsp_result}), 32'(p_rsp));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e[8]));
          chk("rsp_result", 32'(rsp_result), 32'(e[3:0]));
          chk("rsp_flags", 32'(rsp_flags), 32'(e[7:4]));
        end
      end
      p_stall = rsp_valid && !rsp_ready;
      p_rsp   = {rsp_id, rsp_flags, rsp_result};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_count < target && t < 200) begin @(posedge clk); t++; end
    #1;
    if (acc_count < target) chk("accept_timeout", 32'(acc_count), 32'(target));
  endtask

  task automatic wait_rsp(output logic ok);
    int t = 0;
    ok = 1'b0;
    while (t < 50) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
      t++;
    end
    if (!ok) chk("rsp_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    logic ok;
    int   base;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b1;
    req0_opcode = '0; req0_a = '0; req0_b = '0;
    req1_opcode = '0; req1_a = '0; req1_b = '0;
    step(3);
    chk("reset_outputs", 32'({alu_opcode, alu_a, alu_b, alu_start, rsp_valid, rsp_id,
                              rsp_result, rsp_flags, busy}), 32'(0));
    rst_n = 1'b1;

    // Directed add: 7 + 9 wraps to zero with Z and C.
    req0_opcode = ADD_OP; req0_a = 4'd7; req0_b = 4'd9; req_valid = 2'b01;
    wait_acc(1); req_valid = 2'b00;
    wait_rsp(ok);
    if (ok) chk("add_rsp", 32'({rsp_id, rsp_flags, rsp_result}), 32'({1'b0, 4'b0011, 4'h0}));
    step(2);

    // Directed subtract from requester 1: 2 - 5 = D, negative with borrow.
    req1_opcode = SUB_OP; req1_a = 4'd2; req1_b = 4'd5; req_valid = 2'b10;
    wait_acc(2); req_valid = 2'b00;
    wait_rsp(ok);
    if (ok) chk("sub_rsp", 32'({rsp_id, rsp_flags, rsp_result}), 32'({1'b1, 4'b1001, 4'hD}));
    step(2);

    // Contention: both held valid for eight back-to-back ops.
    base = acc_count;
    acc_ids.delete();
    req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      req0_opcode = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_opcode = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      wait_acc(base + i + 1);
    end
    req_valid = 2'b00;
    for (int i = 0; i < 8 && i < acc_ids.size(); i++)
      chk("alternate_grant", 32'(acc_ids[i]), 32'(i % 2));
    step(LAT + 3);

    // Backpressure: hold response for five cycles while a request waits.
    rsp_ready = 1'b0;
    req0_opcode = ADD_OP; req0_a = 4'd3; req0_b = 4'd4; req_valid = 2'b01;
    base = acc_count;
    wait_acc(base + 1);
    wait_rsp(ok);
    @(posedge clk); #1;
    step(4);
    rsp_ready = 1'b1;
    wait_acc(base + 2);
    req_valid = 2'b00;
    step(LAT + 3);

    // Single requester streaming three ops.
    base = acc_count;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      req1_opcode = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      wait_acc(base + i + 1);
    end
    req_valid = 2'b00;
    step(LAT + 3);

    // Randomized traffic with random backpressure and valid withdrawal.
    for (int i = 0; i < 800; i++) begin
      req_valid   = 2'($urandom);
      req0_opcode = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_opcode = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    step(LAT + 3);

    // Reset in the middle of an operation.
    req1_opcode = ADD_OP; req1_a = 4'd1; req1_b = 4'd1; req_valid = 2'b10;
    base = acc_count;
    wait_acc(base + 1);
    req_valid = 2'b00;
    step(1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({alu_opcode, alu_a, alu_b, alu_start, rsp_valid, rsp_id,
                                    rsp_result, rsp_flags, busy, req_ready}), 32'(0));
    step(1);
    rst_n = 1'b1;
    step(LAT + 3);
    acc_ids.delete();
    base = acc_count;
    req_valid = 2'b11;
    wait_acc(base + 1);
    req_valid = 2'b00;
    if (acc_ids.size() > 0) chk("tie_after_reset", 32'(acc_ids[0]), 32'(0));
    step(LAT + 4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
